// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin burst bus arbiter: state encoding,
// default sizing and timeouts, and a constant helper for counter sizing.
package bus_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam int DEF_NUM_MASTERS   = 4;
  localparam int DEF_GRANT_TIMEOUT = 16;
  localparam int DEF_TXN_TIMEOUT   = 1024;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping modulo N; returns one-hot, index and a valid flag.
module rr_priority_picker
  import bus_arbiter_rr_pkg::*;
#(
  parameter int N = DEF_NUM_MASTERS
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         onehot_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 vld_o
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr_i) + i) % N);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin burst bus arbiter with watchdog: holds a grant from begin to end of
// transaction, revokes unused grants and errors out hung transactions.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NUM_MASTERS   = DEF_NUM_MASTERS,
  parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter int TXN_TIMEOUT   = DEF_TXN_TIMEOUT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         request_in,
  input  logic                           begin_transaction_in,
  input  logic                           end_transaction_in,
  input  logic                           error_in,
  output logic [NUM_MASTERS-1:0]         grants_out,
  output logic [$clog2(NUM_MASTERS)-1:0] active_master_out,
  output logic                           bus_idle_out,
  output logic                           error_out,
  output logic                           grant_timeout_out
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(max_int(GRANT_TIMEOUT, TXN_TIMEOUT)) + 1;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grants_q, grants_d;
  logic [IW-1:0]          active_q, active_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          gcnt_q, gcnt_d;
  logic [CW-1:0]          tcnt_q, tcnt_d;
  logic                   err_q, err_d;
  logic                   gto_q, gto_d;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IW-1:0]          pick_idx;
  logic                   pick_vld;

  rr_priority_picker #(.N(NUM_MASTERS)) u_picker (
    .req_i    (request_in),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .vld_o    (pick_vld)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      grants_q <= '0;
      active_q <= '0;
      ptr_q    <= '0;
      gcnt_q   <= '0;
      tcnt_q   <= '0;
      err_q    <= 1'b0;
      gto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grants_q <= grants_d;
      active_q <= active_d;
      ptr_q    <= ptr_d;
      gcnt_q   <= gcnt_d;
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
      gto_q    <= gto_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grants_d = grants_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    gcnt_d   = gcnt_q;
    tcnt_d   = tcnt_q;
    err_d    = 1'b0;
    gto_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grants_d = pick_onehot;
          active_d = pick_idx;
          gcnt_d   = '0;
          state_d  = GRANTED;
        end
      end
      GRANTED: begin
        if (error_in || (!begin_transaction_in && !request_in[active_q])) begin
          state_d  = RELEASE;
          grants_d = '0;
        end else if (begin_transaction_in) begin
          state_d = ACTIVE;
          tcnt_d  = '0;
        end else if (gcnt_q == CW'(GRANT_TIMEOUT - 1)) begin
          state_d  = RELEASE;
          grants_d = '0;
          gto_d    = 1'b1;
        end else begin
          gcnt_d = (&gcnt_q) ? gcnt_q : gcnt_q + 1'b1;
        end
      end
      ACTIVE: begin
        // A timeout first raises error for one cycle with the grant still held,
        // and the counter parks one past the limit so the next cycle releases.
        if (end_transaction_in || error_in || tcnt_q == CW'(TXN_TIMEOUT)) begin
          state_d  = RELEASE;
          grants_d = '0;
        end else begin
          err_d  = (tcnt_q == CW'(TXN_TIMEOUT - 1));
          tcnt_d = (&tcnt_q) ? tcnt_q : tcnt_q + 1'b1;
        end
      end
      RELEASE: begin
        ptr_d   = (int'(active_q) == NUM_MASTERS - 1) ? '0 : active_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grants_out        = grants_q;
  assign active_master_out = active_q;
  assign bus_idle_out      = (state_q == IDLE);
  assign error_out         = err_q;
  assign grant_timeout_out = gto_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: vector table, directed corner cases,
// then random traffic against a transaction-level reference model.
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int GT = 16;
  localparam int TT = 1024;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic       bgn, fin, err;
  logic [3:0] grants_out;
  logic [1:0] active_master_out;
  logic       bus_idle_out, error_out, grant_timeout_out;

  int total = 0;
  int bad   = 0;

  bus_arbiter_rr #(.NUM_MASTERS(N), .GRANT_TIMEOUT(GT), .TXN_TIMEOUT(TT)) dut (
    .clock                (clock),
    .reset                (reset),
    .request_in           (req),
    .begin_transaction_in (bgn),
    .end_transaction_in   (fin),
    .error_in             (err),
    .grants_out           (grants_out),
    .active_master_out    (active_master_out),
    .bus_idle_out         (bus_idle_out),
    .error_out            (error_out),
    .grant_timeout_out    (grant_timeout_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       bgn, fin, err;
    logic [3:0] g;
    logic [1:0] act;
    logic       idle;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic b, input logic f,
                              input logic e, input logic [3:0] g, input logic [1:0] a,
                              input logic idle);
    vec_t v;
    v.rst = r; v.req = q; v.bgn = b; v.fin = f; v.err = e;
    v.g = g; v.act = a; v.idle = idle;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0; bgn = 1'b0; fin = 1'b0; err = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Reference model: who owns the bus, whether a burst is underway, and ages.
  int   m_owner, m_last, m_ptr, m_wait, m_age;
  bit   m_txn, m_turn, m_pend, m_err, m_gto;

  task automatic drop_bus();
    m_owner = -1; m_turn = 1'b1; m_txn = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic [3:0] q, input logic b, input logic f,
                            input logic e);
    m_err = 1'b0;
    m_gto = 1'b0;
    if (r) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_turn = 1'b0; m_txn = 1'b0; m_pend = 1'b0;
    end else if (m_turn) begin
      m_turn = 1'b0;
      m_ptr  = (m_last + 1) % N;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && q[c]) begin
          m_owner = c; m_last = c; m_wait = 0;
        end
      end
    end else if (!m_txn) begin
      if (e) drop_bus();
      else if (b) begin m_txn = 1'b1; m_age = 0; end
      else if (!q[m_owner]) drop_bus();
      else if (m_wait == GT - 1) begin drop_bus(); m_gto = 1'b1; end
      else m_wait++;
    end else begin
      if (f || e || m_pend) drop_bus();
      else if (m_age == TT - 1) begin m_err = 1'b1; m_pend = 1'b1; end
      else m_age++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int order[6];
    int n, cnt, gto_n, err_n, err_at;
    logic [3:0] g_at, g_after, eg;

    // rst req b f e | grants act idle
    vecs[0]  = mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1);
    vecs[1]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1);
    vecs[2]  = mk(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0);
    vecs[3]  = mk(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0);
    vecs[4]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0);
    vecs[5]  = mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0);
    vecs[6]  = mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    vecs[7]  = mk(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1);
    vecs[8]  = mk(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
    vecs[9]  = mk(1'b0, 4'b0101, 1'b1, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
    vecs[10] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b0);
    vecs[11] = mk(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1);
    vecs[12] = mk(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0);
    vecs[13] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    vecs[14] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1);
    vecs[15] = mk(1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b0);
    vecs[16] = mk(1'b0, 4'b1001, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd3, 1'b0);
    vecs[17] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1);
    vecs[18] = mk(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b0);
    vecs[19] = mk(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b0);
    vecs[20] = mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1);
    vecs[21] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1);

    reset = 1'b1; req = 4'b0; bgn = 1'b0; fin = 1'b0; err = 1'b0;
    for (int i = 0; i < 22; i++) begin
      reset = vecs[i].rst; req = vecs[i].req;
      bgn = vecs[i].bgn; fin = vecs[i].fin; err = vecs[i].err;
      tick();
      check($sformatf("vec%0d grants", i), int'(grants_out), int'(vecs[i].g));
      check($sformatf("vec%0d active", i), int'(active_master_out), int'(vecs[i].act));
      check($sformatf("vec%0d idle", i), int'(bus_idle_out), int'(vecs[i].idle));
      check($sformatf("vec%0d error", i), int'(error_out), 0);
      check($sformatf("vec%0d gto", i), int'(grant_timeout_out), 0);
    end

    // Fair rotation among masters 0,1,3 with one-cycle turnaround.
    order = '{0, 1, 3, 0, 1, 3};
    do_reset();
    req = 4'b1011;
    for (int t = 0; t < 6; t++) begin
      n = 0;
      do begin tick(); n++; end while (grants_out == 4'b0 && n < 10);
      check($sformatf("rr grant %0d", t), int'(grants_out), 1 << order[t]);
      if (t > 0) check($sformatf("rr latency %0d", t), n, 2);
      bgn = 1'b1; tick(); bgn = 1'b0;
      tick(); tick();
      fin = 1'b1; tick(); fin = 1'b0;
      check($sformatf("rr gap %0d", t), int'(grants_out), 0);
    end

    // Unused grant to master 2 is revoked after GT cycles; master 3 follows.
    do_reset();
    req = 4'b1100;
    cnt = 0; gto_n = 0;
    tick();
    while (grants_out == 4'b0100 && cnt < 40) begin
      cnt++;
      gto_n += int'(grant_timeout_out);
      tick();
    end
    check("gto grant cycles", cnt, GT);
    check("gto early pulse", gto_n, 0);
    check("gto pulse", int'(grant_timeout_out), 1);
    check("gto revoked", int'(grants_out), 0);
    tick();
    check("gto pulse width", int'(grant_timeout_out), 0);
    check("gto idle", int'(bus_idle_out), 1);
    tick();
    check("gto next master", int'(grants_out), 4'b1000);

    // Hung transaction on master 1: one error pulse with grant held, then drop.
    do_reset();
    req = 4'b0010;
    tick();
    check("txn grant", int'(grants_out), 4'b0010);
    bgn = 1'b1; req = 4'b0; tick(); bgn = 1'b0;
    err_n = 0; err_at = -1; g_at = 4'b0; g_after = 4'b1111;
    for (int k = 1; k <= TT + 2; k++) begin
      tick();
      if (error_out && err_at < 0) err_at = k;
      err_n += int'(error_out);
      if (k == TT) g_at = grants_out;
      if (k == TT + 1) g_after = grants_out;
    end
    check("txn error cycle", err_at, TT);
    check("txn error count", err_n, 1);
    check("txn grant at error", int'(g_at), 4'b0010);
    check("txn grant dropped", int'(g_after), 0);

    // End arriving in the timeout cycle suppresses the error.
    do_reset();
    req = 4'b0010;
    tick();
    bgn = 1'b1; req = 4'b0; tick(); bgn = 1'b0;
    err_n = 0;
    for (int k = 1; k <= TT; k++) begin
      if (k == TT) fin = 1'b1;
      tick();
      err_n += int'(error_out);
    end
    fin = 1'b0;
    check("txn end-wins grant", int'(grants_out), 0);
    tick();
    err_n += int'(error_out);
    check("txn end-wins error", err_n, 0);

    // Reset during master 3's transaction clears the pointer as well.
    do_reset();
    req = 4'b0100; tick();
    check("rst setup grant2", int'(grants_out), 4'b0100);
    req = 4'b0000; tick(); tick();
    req = 4'b1000; tick();
    check("rst setup grant3", int'(grants_out), 4'b1000);
    bgn = 1'b1; tick(); bgn = 1'b0;
    reset = 1'b1; tick();
    check("rst grants", int'(grants_out), 0);
    check("rst idle", int'(bus_idle_out), 1);
    check("rst error", int'(error_out), 0);
    check("rst active", int'(active_master_out), 0);
    reset = 1'b0; req = 4'b1001; tick();
    check("rst pointer", int'(grants_out), 4'b0001);

    // Random traffic against the reference model.
    reset = 1'b1; req = 4'b0; bgn = 1'b0; fin = 1'b0; err = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i > 0) begin
        reset = ($urandom_range(0, 499) == 0);
        if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
        bgn = ($urandom_range(0, 5) == 0);
        fin = ($urandom_range(0, 9) == 0);
        err = ($urandom_range(0, 39) == 0);
      end
      model_step(reset, req, bgn, fin, err);
      tick();
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
      check("rnd grants", int'(grants_out), int'(eg));
      check("rnd active", int'(active_master_out), m_last);
      check("rnd idle", int'(bus_idle_out), int'(m_owner < 0 && !m_turn));
      check("rnd error", int'(error_out), int'(m_err));
      check("rnd gto", int'(grant_timeout_out), int'(m_gto));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
